// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush/redirect controller.
package pipe_ctrl_pkg;

    // Stage bit positions within the stall and flush buses.
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;
    localparam int STALL_W   = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } pipe_state_e;

    // Fixed per-state bus patterns.
    localparam stall_bus_t FLUSH_BRANCH   = 6'b000110;
    localparam stall_bus_t FLUSH_EXCP     = 6'b011111;
    localparam stall_bus_t FLUSH_DRAIN    = 6'b011100;
    localparam stall_bus_t FLUSH_REDIRECT = 6'b000010;
    localparam stall_bus_t STALL_DRAIN    = 6'b000011;

    // The most downstream requester decides how far back the hold reaches.
    function automatic stall_bus_t stall_encode(input logic req_if, input logic req_id,
                                                input logic req_ex, input logic req_mem);
        stall_bus_t s;
        if (req_mem)     s = 6'b011111;
        else if (req_ex) s = 6'b001111;
        else if (req_id) s = 6'b000111;
        else if (req_if) s = 6'b000011;
        else             s = 6'b000000;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and the stall/flush controller.
// new_pc_valid is a one-cycle command with no ready: the PC register must
// load new_pc in the same cycle it is high, and it is never held or repeated.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int PERF_W = 32
);
    import pipe_ctrl_pkg::*;

    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target;
    logic              excp_valid;
    logic              excp_is_ertn;
    logic [ADDR_W-1:0] excp_entry_pc;
    logic [ADDR_W-1:0] era_pc;
    logic              icache_busy;
    stall_bus_t        stall;
    stall_bus_t        flush;
    logic              new_pc_valid;
    logic [ADDR_W-1:0] new_pc;
    logic [PERF_W-1:0] stall_cycles;
    logic [15:0]       excp_count;
    pipe_state_e       state_dbg;

    // Controller side.
    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  branch_flag, branch_target,
        input  excp_valid, excp_is_ertn, excp_entry_pc, era_pc, icache_busy,
        output stall, flush, new_pc_valid, new_pc, stall_cycles, excp_count, state_dbg
    );

    // Pipeline side.
    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output branch_flag, branch_target,
        output excp_valid, excp_is_ertn, excp_entry_pc, era_pc, icache_busy,
        input  stall, flush, new_pc_valid, new_pc, stall_cycles, excp_count, state_dbg
    );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Two independent enabled counters that wrap at their natural width.
module pipe_perf_cnt #(
    parameter int W0 = 32,
    parameter int W1 = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc0,
    input  logic          inc1,
    output logic [W0-1:0] cnt0,
    output logic [W1-1:0] cnt1
);

    // Count enabled cycles; overflow simply wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (inc0) cnt0 <= cnt0 + W0'(1);
            if (inc1) cnt1 <= cnt1 + W1'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller with exception entry sequencing.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int PERF_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.master bus
);

    pipe_state_e       state_q, state_next;
    logic [ADDR_W-1:0] target_q;
    stall_bus_t        stall_raw, flush_c;
    logic              npv_c;
    logic [ADDR_W-1:0] npc_c;
    logic              excp_take;
    logic              stall_inc;

    // State and latched exception/ERTN target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            target_q <= '0;
        end else begin
            state_q <= state_next;
            if (excp_take)
                target_q <= bus.excp_is_ertn ? bus.era_pc : bus.excp_entry_pc;
        end
    end

    // Next state and raw per-state controls.
    always_comb begin
        stall_raw  = '0;
        flush_c    = '0;
        npv_c      = 1'b0;
        npc_c      = '0;
        excp_take  = 1'b0;
        state_next = state_q;
        unique case (state_q)
            ST_RUN: begin
                stall_raw = stall_encode(bus.stallreq_if, bus.stallreq_id,
                                         bus.stallreq_ex, bus.stallreq_mem);
                if (bus.excp_valid) begin
                    // Exception wins over a same-cycle branch; stalls still apply.
                    excp_take  = 1'b1;
                    state_next = ST_FLUSH;
                end else if (bus.branch_flag && !stall_raw[STALL_EX]) begin
                    // A stalled EX keeps the branch and presents it again later.
                    flush_c = FLUSH_BRANCH;
                    npv_c   = 1'b1;
                    npc_c   = bus.branch_target;
                end
            end
            ST_FLUSH: begin
                flush_c    = FLUSH_EXCP;
                state_next = bus.icache_busy ? ST_DRAIN : ST_REDIRECT;
            end
            ST_DRAIN: begin
                stall_raw = STALL_DRAIN;
                flush_c   = FLUSH_DRAIN;
                if (!bus.icache_busy) state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                flush_c    = FLUSH_REDIRECT;
                npv_c      = 1'b1;
                npc_c      = target_q;
                state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Outputs are silent during reset; flush overrides stall per stage.
    always_comb begin
        bus.stall        = rst ? '0 : (stall_raw & ~flush_c);
        bus.flush        = rst ? '0 : flush_c;
        bus.new_pc_valid = rst ? 1'b0 : npv_c;
        bus.new_pc       = rst ? '0 : npc_c;
        bus.state_dbg    = state_q;
    end

    assign stall_inc = (state_q == ST_RUN) && stall_raw[STALL_PC];

    pipe_perf_cnt #(
        .W0(PERF_W),
        .W1(16)
    ) u_perf (
        .clk (clk),
        .rst (rst),
        .inc0(stall_inc),
        .inc1(excp_take),
        .cnt0(bus.stall_cycles),
        .cnt1(bus.excp_count)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: RUN-mode vector table plus exception sequences.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int PERF_W = 32;
    localparam int NVEC   = 12;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [PERF_W-1:0] exp_stall_cnt;

    pipe_ctrl_if #(.ADDR_W(ADDR_W), .PERF_W(PERF_W)) bus ();

    pipe_ctrl #(.ADDR_W(ADDR_W), .PERF_W(PERF_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        req_if;
        logic        req_id;
        logic        req_ex;
        logic        req_mem;
        logic        br;
        logic [31:0] tgt;
        logic [5:0]  exp_stall;
        logic [5:0]  exp_flush;
        logic        exp_npv;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs[NVEC];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.stallreq_if   = 1'b0;
        bus.stallreq_id   = 1'b0;
        bus.stallreq_ex   = 1'b0;
        bus.stallreq_mem  = 1'b0;
        bus.branch_flag   = 1'b0;
        bus.branch_target = '0;
        bus.excp_valid    = 1'b0;
        bus.excp_is_ertn  = 1'b0;
        bus.excp_entry_pc = '0;
        bus.era_pc        = '0;
        bus.icache_busy   = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [5:0] s, input logic [5:0] f,
                              input logic v, input logic [31:0] pc);
        check({tag, ".stall"}, 64'(bus.stall), 64'(s));
        check({tag, ".flush"}, 64'(bus.flush), 64'(f));
        check({tag, ".npv"},   64'(bus.new_pc_valid), 64'(v));
        check({tag, ".npc"},   64'(bus.new_pc), 64'(pc));
    endtask

    task automatic set_vec(input int i, input logic fi, input logic fd, input logic fe,
                           input logic fm, input logic b, input logic [31:0] t,
                           input logic [5:0] s, input logic [5:0] f, input logic v,
                           input logic [31:0] pc);
        vecs[i] = '{fi, fd, fe, fm, b, t, s, f, v, pc};
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_stall_cnt = '0;
        clear_inputs();

        //           if id ex mem br  target        stall      flush      npv npc
        set_vec(0,  0, 1, 0, 0, 0, 32'h0,         6'b000111, 6'b000000, 0, 32'h0);
        set_vec(1,  0, 1, 0, 0, 0, 32'h0,         6'b000111, 6'b000000, 0, 32'h0);
        set_vec(2,  0, 1, 0, 0, 0, 32'h0,         6'b000111, 6'b000000, 0, 32'h0);
        set_vec(3,  0, 1, 0, 1, 0, 32'h0,         6'b011111, 6'b000000, 0, 32'h0);
        set_vec(4,  0, 0, 0, 0, 0, 32'h0,         6'b000000, 6'b000000, 0, 32'h0);
        set_vec(5,  0, 0, 0, 0, 1, 32'h1c000040,  6'b000000, 6'b000110, 1, 32'h1c000040);
        set_vec(6,  0, 0, 1, 0, 1, 32'h1c000040,  6'b001111, 6'b000000, 0, 32'h0);
        set_vec(7,  1, 0, 0, 0, 0, 32'h0,         6'b000011, 6'b000000, 0, 32'h0);
        set_vec(8,  0, 0, 1, 0, 0, 32'h0,         6'b001111, 6'b000000, 0, 32'h0);
        set_vec(9,  1, 1, 1, 0, 0, 32'h0,         6'b001111, 6'b000000, 0, 32'h0);
        set_vec(10, 0, 0, 0, 1, 1, 32'h1c000080,  6'b011111, 6'b000000, 0, 32'h0);
        set_vec(11, 0, 0, 0, 0, 1, 32'h1c0000a0,  6'b000000, 6'b000110, 1, 32'h1c0000a0);

        // Reset with busy inputs: outputs must stay quiet.
        rst = 1'b1;
        bus.stallreq_mem  = 1'b1;
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h1c000040;
        bus.excp_valid    = 1'b1;
        @(negedge clk);
        #1;
        check_outs("rst", 6'b0, 6'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("rst.state",   64'(bus.state_dbg), 64'(ST_RUN));
        check("rst.stall_cycles", 64'(bus.stall_cycles), 64'h0);
        check("rst.excp_count",   64'(bus.excp_count), 64'h0);
        clear_inputs();
        rst = 1'b0;

        // RUN-mode vector table.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus.stallreq_if   = vecs[i].req_if;
            bus.stallreq_id   = vecs[i].req_id;
            bus.stallreq_ex   = vecs[i].req_ex;
            bus.stallreq_mem  = vecs[i].req_mem;
            bus.branch_flag   = vecs[i].br;
            bus.branch_target = vecs[i].tgt;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush,
                       vecs[i].exp_npv, vecs[i].exp_npc);
            if (vecs[i].exp_stall[0]) exp_stall_cnt++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        check("table.stall_cycles", 64'(bus.stall_cycles), 64'(exp_stall_cnt));

        // Exception, icache idle: FLUSH then REDIRECT.
        bus.excp_valid    = 1'b1;
        bus.excp_entry_pc = 32'h1c008000;
        bus.era_pc        = 32'h1c000999;
        #1;
        check_outs("exc.run", 6'b0, 6'b0, 1'b0, 32'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        check("exc.state1", 64'(bus.state_dbg), 64'(ST_FLUSH));
        check_outs("exc.flush", 6'b0, 6'b011111, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("exc.state2", 64'(bus.state_dbg), 64'(ST_REDIRECT));
        check_outs("exc.redir", 6'b0, 6'b000010, 1'b1, 32'h1c008000);
        check("exc.count", 64'(bus.excp_count), 64'd1);
        @(negedge clk);
        #1;
        check("exc.state3", 64'(bus.state_dbg), 64'(ST_RUN));
        check_outs("exc.after", 6'b0, 6'b0, 1'b0, 32'h0);

        // ERTN with icache busy: FLUSH, four DRAIN cycles, REDIRECT to ERA.
        bus.excp_valid    = 1'b1;
        bus.excp_is_ertn  = 1'b1;
        bus.era_pc        = 32'h1c000124;
        bus.excp_entry_pc = 32'h1c008000;
        bus.icache_busy   = 1'b1;
        @(negedge clk);
        bus.excp_valid = 1'b0;
        #1;
        check("ertn.state_flush", 64'(bus.state_dbg), 64'(ST_FLUSH));
        check_outs("ertn.flush", 6'b0, 6'b011111, 1'b0, 32'h0);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            // Requests during DRAIN must have no effect.
            bus.stallreq_mem  = 1'b1;
            bus.branch_flag   = 1'b1;
            bus.branch_target = 32'h1c000040;
            bus.excp_valid    = 1'b1;
            bus.icache_busy   = (d < 3);
            #1;
            check($sformatf("ertn.state_drain%0d", d), 64'(bus.state_dbg), 64'(ST_DRAIN));
            check_outs($sformatf("ertn.drain%0d", d), 6'b000011, 6'b011100, 1'b0, 32'h0);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        check("ertn.state_redir", 64'(bus.state_dbg), 64'(ST_REDIRECT));
        check_outs("ertn.redir", 6'b0, 6'b000010, 1'b1, 32'h1c000124);
        check("ertn.count", 64'(bus.excp_count), 64'd2);

        // Exception and branch in the same cycle: only the exception redirect.
        @(negedge clk);
        bus.excp_valid    = 1'b1;
        bus.excp_entry_pc = 32'h1c008000;
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h1c000040;
        #1;
        check_outs("both.run", 6'b0, 6'b0, 1'b0, 32'h0);
        @(negedge clk);
        bus.excp_valid = 1'b0;
        #1;
        check_outs("both.flush", 6'b0, 6'b011111, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check_outs("both.redir", 6'b0, 6'b000010, 1'b1, 32'h1c008000);
        check("both.count", 64'(bus.excp_count), 64'd3);
        check("both.stall_cycles", 64'(bus.stall_cycles), 64'(exp_stall_cnt));

        // Reset in the middle of DRAIN.
        @(negedge clk);
        clear_inputs();
        bus.excp_valid    = 1'b1;
        bus.excp_entry_pc = 32'h1c00f000;
        bus.icache_busy   = 1'b1;
        @(negedge clk);
        bus.excp_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rstd.state_drain", 64'(bus.state_dbg), 64'(ST_DRAIN));
        rst = 1'b1;
        #1;
        check_outs("rstd.during", 6'b0, 6'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstd.state", 64'(bus.state_dbg), 64'(ST_RUN));
        check("rstd.stall_cycles", 64'(bus.stall_cycles), 64'h0);
        check("rstd.excp_count",   64'(bus.excp_count), 64'h0);
        for (int k = 0; k < 3; k++) begin
            check_outs($sformatf("rstd.after%0d", k), 6'b0, 6'b0, 1'b0, 32'h0);
            @(negedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/redirect controller for the 5-stage in-order pipeline (PC, IF, ID, EX, MEM, WB).
- Collects stall requests from the stages, branch redirects from EX, and exception/ERTN events from the MEM commit point.
- Drives per-stage stall and flush vectors that every pipeline register (if_id, id_ex, ex_mem, mem_wb) obeys, plus the PC redirect.
- Sequences the exception entry: flush, then drain any outstanding icache request, then redirect.

Parameters:
- ADDR_W, 32, PC/target address width
- PERF_W, 32, width of the stall-cycle performance counter

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stallreq_if  in  1  IF stage needs to hold (icache miss)
- stallreq_id  in  1  ID stage needs to hold (load-use hazard)
- stallreq_ex  in  1  EX stage needs to hold (multi-cycle mul/div)
- stallreq_mem  in  1  MEM stage needs to hold (dcache miss)
- branch_flag  in  1  EX resolved a taken/mispredicted branch this cycle
- branch_target  in  ADDR_W  branch redirect PC
- excp_valid  in  1  exception or ERTN committing in MEM this cycle
- excp_is_ertn  in  1  qualifies excp_valid: 1 = ERTN, 0 = exception
- excp_entry_pc  in  ADDR_W  exception handler entry (EENTRY)
- era_pc  in  ADDR_W  ERTN return address (ERA)
- icache_busy  in  1  icache has an in-flight refill that must not be abandoned
- stall  out  6  per-stage hold, bit0=PC … bit5=WB
- flush  out  6  per-stage clear-to-bubble, same bit order
- new_pc_valid  out  1  PC must load new_pc this cycle
- new_pc  out  ADDR_W  redirect address
- stall_cycles  out  PERF_W  count of cycles with stall[0]=1 in RUN
- excp_count  out  16  exceptions and ERTNs taken

Behaviour:
- Decided interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state=RUN; target register, stall_cycles and excp_count cleared.
  - While rst=1, stall, flush, new_pc_valid and new_pc are all 0.
- stall, flush, new_pc_valid and new_pc are combinational from state and inputs. stall_cycles and excp_count are registered.
- FSM states: RUN, FLUSH, DRAIN, REDIRECT.
- RUN, stall encoding (highest requester wins):
  - mem → 011111
  - ex → 001111
  - id → 000111
  - if → 000011
  - none → 000000
  - A pipeline register whose source stage is stalled and whose own stage is not inserts a bubble. That logic lives in the register, not here.
- RUN, branch:
  - When branch_flag=1 and stall[3]=0: flush=000110 (IF, ID), new_pc_valid=1, new_pc=branch_target, same cycle.
  - When stall[3]=1 the branch is ignored. EX holds it and presents it again.
- RUN, excp_valid=1:
  - Latch target = excp_is_ertn ? era_pc : excp_entry_pc, increment excp_count, next state FLUSH.
  - excp_valid beats branch_flag in the same cycle: the branch is dropped and no branch redirect is issued.
  - excp_valid beats stall requests: the cycle's stall/flush outputs still follow the RUN encoding.
- FLUSH (1 cycle):
  - flush=011111 (PC..MEM; WB keeps its committed value), stall=000000.
  - Next state DRAIN if icache_busy, else REDIRECT.
- DRAIN:
  - stall=000011, flush=011100.
  - Stay while icache_busy=1; leave to REDIRECT on the first cycle it is 0.
  - Does not time out.
- REDIRECT (1 cycle):
  - new_pc_valid=1, new_pc=latched target, flush=000010, stall=0.
  - Next state RUN.
- excp_valid, branch_flag and stallreq_* are ignored in FLUSH, DRAIN and REDIRECT.
- Counter width rules: stall_cycles wraps at 2^PERF_W; excp_count wraps at 2^16.
- rst in any state, including mid-DRAIN: return to RUN with no redirect issued.
- Flush has priority over stall for any stage where both are set.

Decomposition:
- defines.v gains:
  - Stage index macros: `StallPC=0, `StallIF=1, `StallID=2, `StallEX=3, `StallMEM=4, `StallWB=5.
  - The 2-bit state encodings: RUN=0, FLUSH=1, DRAIN=2, REDIRECT=3.
  - `StallBus [5:0].
- One sub-module, pipe_perf_cnt: holds the two enabled, wrapping counters so they can be reused for other perf events.

Test Plan:
- stallreq_id=1, stallreq_mem=0 for 3 cycles → stall=000111 each cycle, flush=0, stall_cycles +3; then stallreq_mem=1 together with stallreq_id → stall=011111.
- branch_flag=1, target=0x1c000040, no stalls → same cycle flush=000110, new_pc_valid=1, new_pc=0x1c000040; repeat with stallreq_ex=1 → new_pc_valid=0, flush=0.
- excp_valid=1, ertn=0, entry=0x1c008000, icache_busy=0 → next cycle flush=011111; cycle after, new_pc_valid=1 with new_pc=0x1c008000; excp_count=1; back in RUN.
- ERTN with era=0x1c000124, icache_busy=1 for 4 cycles → FLUSH, 4 DRAIN cycles with stall=000011, then REDIRECT to 0x1c000124.
- excp_valid and branch_flag in the same cycle → no branch redirect that cycle; only the exception redirect is issued, after FLUSH.
- Assert rst during DRAIN → next cycle all outputs 0, state RUN, no new_pc_valid pulse afterwards, both counters 0.
